// File: rtl/imem_load_ctrl_if.sv
// Bus bundle between the instruction-memory load controller and its
// surroundings: core fetch path, byte loader stream and memory write port.
interface imem_load_ctrl_if #(
    parameter int MEM_SIZE = 256
);
    localparam int CW = $clog2(MEM_SIZE) + 1;

    logic [31:0]   cpu_addr;
    logic [31:0]   mem_addr;
    logic          cpu_hold;
    logic          pc_restart;
    logic          load_start;
    logic          load_done;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          wr_en;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic [CW-1:0] words_loaded;

    // Controller side
    modport master (
        input  cpu_addr, load_start, load_done, byte_valid, byte_data,
        output mem_addr, cpu_hold, pc_restart, byte_ready,
               wr_en, wr_addr, wr_data, words_loaded
    );

    // Core / loader / memory side
    modport slave (
        output cpu_addr, load_start, load_done, byte_valid, byte_data,
        input  mem_addr, cpu_hold, pc_restart, byte_ready,
               wr_en, wr_addr, wr_data, words_loaded
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction memory load controller. In RUN the core fetch address goes
// straight to the ROM; in LOAD the core is held while a byte stream is packed
// little-endian into words and written from address 0 upward, after which the
// core PC is restarted at 0.
module imem_load_ctrl #(
    parameter int MEM_SIZE  = 256,
    parameter bit BOOT_LOAD = 1'b0
) (
    input logic          clk,
    input logic          rst,
    imem_load_ctrl_if.master bus
);
    localparam int CW = $clog2(MEM_SIZE) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MEM_SIZE);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {RUN, LOAD, FLUSH, RELEASE} state_t;

    state_t        state, state_n;
    logic [1:0]    byte_cnt, byte_cnt_n;
    logic [CW-1:0] word_cnt, word_cnt_n;
    logic [CW-1:0] words, words_n;
    logic [31:0]   asm_reg, asm_n;
    // Set in LOAD while the final word write is on the bus; the next cycle
    // goes to RELEASE and no more bytes are taken.
    logic          ending, ending_n;

    logic          cpu_hold, byte_ready, pc_restart, wr_en;
    logic [31:0]   wr_addr, wr_data;
    logic          wr_en_n;
    logic [31:0]   wr_addr_n, wr_data_n;

    logic          accept;
    logic [31:0]   asm_upd;
    logic [2:0]    cnt_upd;
    logic [31:0]   cur_addr;

    assign bus.mem_addr     = cpu_hold ? 32'h0 : bus.cpu_addr;
    assign bus.cpu_hold     = cpu_hold;
    assign bus.byte_ready   = byte_ready;
    assign bus.pc_restart   = pc_restart;
    assign bus.wr_en        = wr_en;
    assign bus.wr_addr      = wr_addr;
    assign bus.wr_data      = wr_data;
    assign bus.words_loaded = words;

    // Register all state and the registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT_LOAD ? LOAD : RUN;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            words      <= '0;
            asm_reg    <= '0;
            ending     <= 1'b0;
            cpu_hold   <= BOOT_LOAD;
            byte_ready <= BOOT_LOAD;
            pc_restart <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state      <= state_n;
            byte_cnt   <= byte_cnt_n;
            word_cnt   <= word_cnt_n;
            words      <= words_n;
            asm_reg    <= asm_n;
            ending     <= ending_n;
            cpu_hold   <= (state_n != RUN);
            byte_ready <= (state_n == LOAD) && !ending_n;
            pc_restart <= (state_n == RELEASE);
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
        end
    end

    // Next state, byte packing and write-port scheduling
    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        word_cnt_n = word_cnt;
        words_n    = words;
        asm_n      = asm_reg;
        ending_n   = ending;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;

        accept   = bus.byte_valid && byte_ready;
        asm_upd  = asm_reg;
        if (accept)
            asm_upd[{byte_cnt, 3'b000} +: 8] = bus.byte_data;
        cnt_upd  = {1'b0, byte_cnt} + {2'b00, accept};
        cur_addr = {{(30-CW){1'b0}}, word_cnt, 2'b00};

        case (state)
            RUN: begin
                // load_done is deliberately ignored here, even alongside load_start
                if (bus.load_start) begin
                    state_n    = LOAD;
                    byte_cnt_n = '0;
                    word_cnt_n = '0;
                    words_n    = '0;
                    asm_n      = '0;
                    ending_n   = 1'b0;
                end
            end
            LOAD: begin
                if (ending) begin
                    state_n  = RELEASE;
                    ending_n = 1'b0;
                end else if (cnt_upd == 3'd4) begin
                    // Full word: write it; a concurrent done or a full memory
                    // finishes after this write without a flush.
                    wr_en_n    = 1'b1;
                    wr_addr_n  = cur_addr;
                    wr_data_n  = asm_upd;
                    word_cnt_n = word_cnt + ONE;
                    words_n    = words + ONE;
                    byte_cnt_n = '0;
                    asm_n      = '0;
                    if (bus.load_done || (word_cnt + ONE) == FULL_CNT)
                        ending_n = 1'b1;
                end else if (bus.load_done) begin
                    if (cnt_upd == 3'd0) begin
                        state_n = RELEASE;
                    end else begin
                        // Partial word: upper lanes are still zero in asm_upd
                        state_n    = FLUSH;
                        wr_en_n    = 1'b1;
                        wr_addr_n  = cur_addr;
                        wr_data_n  = asm_upd;
                        word_cnt_n = word_cnt + ONE;
                        words_n    = words + ONE;
                        byte_cnt_n = '0;
                        asm_n      = '0;
                    end
                end else begin
                    byte_cnt_n = cnt_upd[1:0];
                    asm_n      = asm_upd;
                end
            end
            FLUSH:   state_n = RELEASE;
            RELEASE: state_n = RUN;
            default: state_n = RUN;
        endcase
    end
endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Sequences the instruction memory between two users: the single-cycle core's fetch path and a byte-wide program loader.
- In RUN, the core's fetch address passes straight through to the instruction ROM.
- In LOAD, the core is held. Incoming bytes are packed little-endian into 32-bit words and written to the memory write port at byte addresses 0, 4, 8, ...
- At the end of a load, the core's PC is restarted at 0.

Parameters:
- MEM_SIZE, 256, instruction memory depth in 32-bit words. Must be a power of two, ≥4.
- BOOT_LOAD, 0, when 1 the reset state is LOAD instead of RUN.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr  in  32  core fetch byte address (PC).
- mem_addr  out  32  address to instruction memory read port (combinational).
- cpu_hold  out  1  core must not advance its PC (registered).
- pc_restart  out  1  one-cycle pulse: core loads PC=0 (registered).
- load_start  in  1  request to enter LOAD. Sampled in RUN only.
- load_done  in  1  end of program stream. Sampled in LOAD only.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  program byte.
- byte_ready  out  1  controller accepts a byte this cycle (registered).
- wr_en  out  1  memory write strobe (registered).
- wr_addr  out  32  write byte address, word-aligned (registered).
- wr_data  out  32  write data (registered).
- words_loaded  out  $clog2(MEM_SIZE)+1  words written in the current or last load.

Behaviour:
- **Reset (async, rst=1)**
  - State = RUN, or LOAD if BOOT_LOAD=1.
  - byte_cnt=0, word_cnt=0, asm_reg=0.
  - wr_en=0, wr_addr=0, wr_data=0, pc_restart=0, words_loaded=0.
  - cpu_hold=0 and byte_ready=0 in RUN; cpu_hold=1 and byte_ready=1 if BOOT_LOAD=1.
  - Reset mid-load abandons the load. Words already written stay in memory.
- **Byte handshake**
  - A byte transfers when byte_valid && byte_ready on a clock edge.
- **mem_addr**
  - cpu_hold ? 32'h0 : cpu_addr, purely combinational.
- **States**
  - RUN
    - cpu_hold=0, byte_ready=0.
    - load_start=1 → LOAD; clear byte_cnt, word_cnt and words_loaded. cpu_hold=1 and byte_ready=1 from the next cycle.
  - LOAD
    - cpu_hold=1. byte_ready=1 except in the cycle after the last word is written.
    - Each accepted byte goes into asm_reg lane byte_cnt (lane 0 = bits 7:0), then byte_cnt increments.
    - On the 4th byte: the next cycle has wr_en=1, wr_addr=word_cnt*4, wr_data=assembled word. Then word_cnt and words_loaded increment and byte_cnt=0.
    - The write that makes word_cnt == MEM_SIZE → RELEASE. byte_ready=0 from that cycle on; further bytes are not accepted.
    - load_done=1 with byte_cnt==0 → RELEASE.
    - load_done=1 with byte_cnt!=0 → FLUSH.
    - Byte accepted in the same cycle as load_done: the byte is included first, then the done rule is evaluated on the updated byte_cnt. A 4th byte plus done means a normal write, then RELEASE.
    - load_start in LOAD is ignored.
  - FLUSH
    - byte_ready=0. One cycle with wr_en=1 writing the partial word; unfilled upper lanes are 0. words_loaded increments.
    - → RELEASE.
  - RELEASE
    - cpu_hold=1, byte_ready=0. pc_restart=1 for exactly this one cycle.
    - → RUN next cycle, with cpu_hold=0 and pc_restart=0.
- **Output timing**
  - wr_en is high for exactly one cycle per word and never outside LOAD/FLUSH.
- **Widths**
  - word_cnt is $clog2(MEM_SIZE)+1 bits and never exceeds MEM_SIZE.
  - wr_addr upper bits are zero.
- **Edge case**
  - load_done in the same cycle as load_start in RUN: load_done is ignored. The controller enters LOAD.

Test Plan:
- Reset in RUN, cpu_addr=0x0000_0010 → mem_addr=0x10, cpu_hold=0, wr_en=0, pc_restart=0.
- load_start, then bytes 0x13,0x00,0x50,0x00,0xB7,0x02,0x00,0x00, then load_done → writes (0x0, 0x00500013) and (0x4, 0x000002B7); words_loaded=2; pc_restart pulses once; cpu_hold drops the next cycle.
- Bytes 0xAA,0xBB,0xCC then load_done → FLUSH writes (0x0, 0x00CCBBAA); words_loaded=1.
- 4th byte 0x11 accepted in the same cycle as load_done → a single full-word write, no FLUSH write, then RELEASE.
- MEM_SIZE=4: stream 20 bytes with byte_valid held high → exactly 4 writes (addr 0xC last); byte_ready=0 after the 16th byte; words_loaded=4; RELEASE follows without load_done.
- Assert rst after 2 words of a load → outputs return to reset values immediately; cpu_hold=0; the next load_start restarts writing at wr_addr=0.
